// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axis_arb_pkg;

    // Arbiter FSM: waiting to pick a port, or forwarding a granted packet
    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_e;

    // Grant index width; a single-port build still needs a 1-bit index
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_pkt_arbiter_rr_select.sv
// Round-robin picker: first requester after last_grant, wrapping.
// Latency: purely combinational.
// Backpressure: none; result is only consumed while the arbiter is idle.
module rr_select
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    localparam int GW = grant_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GW-1:0]        last_grant,
    output logic                 any_req,
    output logic [GW-1:0]        sel
);

    logic [2*NUM_PORTS-1:0] dbl;
    logic [2*NUM_PORTS-1:0] masked;
    int                     start;

    // Unroll the request vector twice and keep the window of NUM_PORTS bits
    // starting just after the previous winner; the lowest surviving bit wins.
    always_comb begin
        start   = (int'(last_grant) >= NUM_PORTS - 1) ? 0 : int'(last_grant) + 1;
        dbl     = {req, req};
        masked  = '0;
        any_req = |req;
        sel     = '0;
        for (int i = 0; i < 2 * NUM_PORTS; i++) begin
            masked[i] = dbl[i] && (i >= start) && (i < start + NUM_PORTS);
        end
        for (int i = 2 * NUM_PORTS - 1; i >= 0; i--) begin
            if (masked[i]) begin
                sel = GW'(i % NUM_PORTS);
            end
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI-Stream sources into one.
// Latency: 1 idle arbitration cycle per packet, then zero-latency pass-through.
// Backpressure: m_tready routed straight to the granted s_tready; others held at 0.
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS        = 4,
    parameter int AXIS_DATA_WIDTH  = 512,
    parameter int AXIS_TUSER_WIDTH = 256,
    parameter int CNT_WIDTH        = 32,
    localparam int GW              = grant_w(NUM_PORTS),
    localparam int KW              = AXIS_DATA_WIDTH / 8
) (
    input  logic                              aclk,
    input  logic                              reset,
    input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0]  s_tdata,
    input  logic [NUM_PORTS*KW-1:0]               s_tkeep,
    input  logic [NUM_PORTS*AXIS_TUSER_WIDTH-1:0] s_tuser,
    input  logic [NUM_PORTS-1:0]              s_tvalid,
    input  logic [NUM_PORTS-1:0]              s_tlast,
    output logic [NUM_PORTS-1:0]              s_tready,
    output logic [AXIS_DATA_WIDTH-1:0]        m_tdata,
    output logic [KW-1:0]                     m_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]       m_tuser,
    output logic                              m_tvalid,
    output logic                              m_tlast,
    input  logic                              m_tready,
    output logic [GW-1:0]                     grant_id,
    output logic                              busy,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]    pkt_count
);

    arb_state_e           state;
    logic [GW-1:0]        last_grant;
    logic                 any_req;
    logic [GW-1:0]        sel;
    logic                 passing;
    logic                 beat_done;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_PORTS];

    rr_select #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_select (
        .req        (s_tvalid),
        .last_grant (last_grant),
        .any_req    (any_req),
        .sel        (sel)
    );

    // Forwarding is suppressed during reset so nothing handshakes on a reset edge
    assign passing   = (state == PASS) && !reset;
    assign beat_done = m_tvalid && m_tready && m_tlast;

    // Steer the granted slice to the master side and route ready back to it
    always_comb begin
        m_tdata  = s_tdata[int'(grant_id)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        m_tkeep  = s_tkeep[int'(grant_id)*KW +: KW];
        m_tuser  = s_tuser[int'(grant_id)*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH];
        m_tlast  = s_tlast[grant_id];
        m_tvalid = passing && s_tvalid[grant_id];
        s_tready = '0;
        if (passing) begin
            s_tready[grant_id] = m_tready;
        end
    end

    // Grant FSM: pick in IDLE, hold the grant until the tlast handshake
    always_ff @(posedge aclk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GW'(NUM_PORTS - 1);
            grant_id   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= sel;
                        state    <= PASS;
                        busy     <= 1'b1;
                    end
                end
                PASS: begin
                    if (beat_done) begin
                        last_grant <= grant_id;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Per-port completed-packet counters, free-running with natural wrap
    always_ff @(posedge aclk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                cnt_q[p] <= '0;
            end
        end else if (beat_done) begin
            cnt_q[grant_id] <= cnt_q[grant_id] + CNT_WIDTH'(1);
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt_out
        assign pkt_count[p*CNT_WIDTH +: CNT_WIDTH] = cnt_q[p];
    end

endmodule
